config_loader: RTL and testbench

- Serial configuration port for the fabric.
- Hunts for a sync byte, then shifts in one full configuration frame and checks a CRC-8 over the frame.
- On a good CRC it commits the frame in one step to the flat configuration buses that feed the logic tile LUT memories and the switch box crossbar enables.
- Sits between the external programming pin pair (cfg_data/cfg_valid) and the fabric top.

---
 rtl/cfg_pkg.sv | 20 ++
 rtl/crc8_serial.sv | 26 ++
 rtl/config_loader.sv | 115 +++++++++++
 tb/tb_config_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_pkg.sv
// Shared sizing, sync pattern, CRC polynomial and loader state encoding for
// the serial configuration path.
package cfg_pkg;

    localparam int unsigned N_TILES    = 11;
    localparam int unsigned TILE_BITS  = 33;
    localparam int unsigned N_SB       = 20;
    localparam int unsigned SB_BITS    = 16;
    localparam int unsigned FRAME_BITS = N_TILES * TILE_BITS + N_SB * SB_BITS;

    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        FRAME = 2'd1,
        CRC   = 2'd2
    } state_e;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (MSB-first, no reflection, no final XOR); clear wins over enable.
module crc8_serial
    import cfg_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic fb;
    assign fb = crc[7] ^ bit_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (enable) begin
            crc <= {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: hunts for SYNC, shifts in one frame plus CRC-8,
// and commits the whole frame to the fabric config buses only on a CRC match.
module config_loader
    import cfg_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            cfg_data,
    input  logic                            cfg_valid,
    output logic [N_TILES*TILE_BITS-1:0]    cfg_tile,
    output logic [N_SB*SB_BITS-1:0]         cfg_sb,
    output logic                            cfg_ready,
    output logic                            cfg_done,
    output logic                            cfg_error,
    output logic                            busy
);

    localparam int unsigned TILE_W = N_TILES * TILE_BITS;
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS);

    state_e                  state_q;
    logic [7:0]              sync_q;
    logic [FRAME_BITS-1:0]   shadow_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [7:0]              rx_crc_q;
    logic [7:0]              crc_calc;

    logic [7:0] sync_next;
    logic [7:0] rx_crc_next;
    logic       sync_hit;
    logic       crc_clear;
    logic       crc_enable;

    assign sync_next   = {sync_q[6:0], cfg_data};
    assign rx_crc_next = {rx_crc_q[6:0], cfg_data};
    assign sync_hit    = (sync_next == SYNC);
    assign crc_clear   = cfg_valid && (state_q == HUNT) && sync_hit;
    assign crc_enable  = cfg_valid && (state_q == FRAME);

    crc8_serial u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .enable  (crc_enable),
        .bit_in  (cfg_data),
        .crc     (crc_calc)
    );

    // Loader FSM; nothing advances on cycles without cfg_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= HUNT;
            sync_q    <= 8'h00;
            shadow_q  <= '0;
            cnt_q     <= '0;
            rx_crc_q  <= 8'h00;
            cfg_tile  <= '0;
            cfg_sb    <= '0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            if (cfg_valid) begin
                unique case (state_q)
                    HUNT: begin
                        if (sync_hit) begin
                            state_q <= FRAME;
                            busy    <= 1'b1;
                            cnt_q   <= '0;
                            sync_q  <= 8'h00;
                        end else begin
                            sync_q  <= sync_next;
                        end
                    end
                    FRAME: begin
                        shadow_q <= {cfg_data, shadow_q[FRAME_BITS-1:1]};
                        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            state_q <= CRC;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                    CRC: begin
                        rx_crc_q <= rx_crc_next;
                        if (cnt_q == CNT_W'(7)) begin
                            // Single-step commit keeps the fabric from ever seeing a partial frame.
                            if (rx_crc_next == crc_calc) begin
                                cfg_tile  <= shadow_q[TILE_W-1:0];
                                cfg_sb    <= shadow_q[FRAME_BITS-1:TILE_W];
                                cfg_ready <= 1'b1;
                                cfg_done  <= 1'b1;
                            end else begin
                                cfg_error <= 1'b1;
                            end
                            state_q <= HUNT;
                            busy    <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: vector table of frames plus hand-written
// hunt, garbage and mid-frame reset sequences, with a scoreboard of commit results.
module tb_config_loader;
    import cfg_pkg::*;

    localparam int unsigned TW = N_TILES * TILE_BITS;
    localparam int unsigned SW = N_SB * SB_BITS;
    localparam int unsigned FB = FRAME_BITS;

    typedef struct {
        string      name;
        int         pat;
        int         idx;
        logic [7:0] cx;
        bit         gaps;
        bit         exp_done;
    } vec_t;

    typedef struct {
        logic          done;
        logic          err;
        logic          ready;
        logic [TW-1:0] tile;
        logic [SW-1:0] sb;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cfg_data;
    logic          cfg_valid;
    logic [TW-1:0] cfg_tile;
    logic [SW-1:0] cfg_sb;
    logic          cfg_ready;
    logic          cfg_done;
    logic          cfg_error;
    logic          busy;

    config_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_tile  (cfg_tile),
        .cfg_sb    (cfg_sb),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    int n_err  = 0;
    string cur = "init";

    exp_t          sb_q[$];
    logic [TW-1:0] model_tile  = '0;
    logic [SW-1:0] model_sb    = '0;
    logic          model_ready = 1'b0;
    logic [FB-1:0] rnd_frame;

    always @(negedge clock) begin
        if (cfg_done === 1'b1)  n_done++;
        if (cfg_error === 1'b1) n_err++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got %0h expected %0h", cur, nm, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [FB-1:0] f);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < int'(FB); i++) begin
            fb = c[7] ^ f[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic vec_t mk(input string n, input int p, input int i,
                                input logic [7:0] x, input bit g, input bit d);
        vec_t v;
        v.name = n; v.pat = p; v.idx = i; v.cx = x; v.gaps = g; v.exp_done = d;
        return v;
    endfunction

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps && $urandom_range(0, 9) == 0) begin
            cfg_valid = 1'b0;
            cfg_data  = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 5)) @(posedge clock);
            #1;
        end
        cfg_valid = 1'b1;
        cfg_data  = b;
        @(posedge clock);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    task automatic send_frame(input logic [FB-1:0] f, input logic [7:0] c,
                              input bit gaps, input int pre_n);
        logic [11:0] pre;
        pre = 12'b1111_0101_1010;
        send_byte(8'h00, 1'b0);
        for (int i = 11; i > 11 - pre_n; i--) send_bit(pre[i], 1'b0);
        send_byte(SYNC, gaps);
        for (int i = 0; i < int'(FB); i++) begin
            if (i == 400) begin
                chk("static_tile", cfg_tile, model_tile);
                chk("static_sb", cfg_sb, model_sb);
                if (gaps) begin
                    cfg_valid = 1'b0;
                    repeat (3) @(posedge clock);
                    #1;
                    chk("busy_gap", busy, 1'b1);
                end
            end
            send_bit(f[i], gaps);
        end
        send_byte(c, gaps);
    endtask

    task automatic run_frame(input string nm, input logic [FB-1:0] f, input logic [7:0] cx,
                             input bit gaps, input int pre_n, input bit exp_done);
        exp_t e;
        exp_t got;
        int   d0;
        int   e0;
        cur     = nm;
        e.done  = exp_done;
        e.err   = !exp_done;
        e.ready = exp_done ? 1'b1 : model_ready;
        e.tile  = exp_done ? f[TW-1:0] : model_tile;
        e.sb    = exp_done ? f[FB-1:TW] : model_sb;
        sb_q.push_back(e);
        d0 = n_done;
        e0 = n_err;
        send_frame(f, crc_of(f) ^ cx, gaps, pre_n);
        got = sb_q.pop_front();
        chk("done", cfg_done, got.done);
        chk("error", cfg_error, got.err);
        chk("ready", cfg_ready, got.ready);
        chk("tile", cfg_tile, got.tile);
        chk("sb", cfg_sb, got.sb);
        chk("busy_idle", busy, 1'b0);
        @(posedge clock);
        #1;
        chk("pulse_end", {cfg_done, cfg_error}, 2'b00);
        chk("done_count", n_done - d0, got.done);
        chk("err_count", n_err - e0, got.err);
        if (exp_done) begin
            model_tile  = f[TW-1:0];
            model_sb    = f[FB-1:TW];
            model_ready = 1'b1;
        end
    endtask

    initial begin
        vec_t          vecs[9];
        logic [FB-1:0] f;
        logic [7:0]    sh;
        logic          b;
        int            d0;
        int            e0;

        vecs[0] = mk("zero",         0, 0,        8'h00, 1'b0, 1'b1);
        vecs[1] = mk("walk_tile0",   2, 0,        8'h00, 1'b0, 1'b1);
        vecs[2] = mk("walk_sb0",     2, TW,       8'h00, 1'b0, 1'b1);
        vecs[3] = mk("ones",         1, 0,        8'h00, 1'b0, 1'b1);
        vecs[4] = mk("zero_badcrc",  0, 0,        8'h01, 1'b0, 1'b0);
        vecs[5] = mk("rand",         3, 0,        8'h00, 1'b0, 1'b1);
        vecs[6] = mk("rand_gaps",    3, 0,        8'h00, 1'b1, 1'b1);
        vecs[7] = mk("rand_bad_gap", 3, 0,        8'h80, 1'b1, 1'b0);
        vecs[8] = mk("walk_last",    2, FB - 1,   8'h00, 1'b0, 1'b1);
        for (int i = 0; i < int'(FB); i++) rnd_frame[i] = 1'($urandom_range(0, 1));

        reset_n   = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        cur = "reset";
        chk("tile", cfg_tile, '0);
        chk("sb", cfg_sb, '0);
        chk("ready", cfg_ready, 1'b0);
        chk("done", cfg_done, 1'b0);
        chk("error", cfg_error, 1'b0);
        chk("busy", busy, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int v = 0; v < 9; v++) begin
            case (vecs[v].pat)
                0:       f = '0;
                1:       f = '1;
                2:       begin f = '0; f[vecs[v].idx] = 1'b1; end
                default: f = rnd_frame;
            endcase
            run_frame(vecs[v].name, f, vecs[v].cx, vecs[v].gaps, 0, vecs[v].exp_done);
        end

        // Sync preceded by near-miss bits: frame must align to the A5 that follows them.
        f = ~rnd_frame;
        run_frame("hunt_prefix", f, 8'h00, 1'b0, 12, 1'b1);

        // Garbage that never forms SYNC must not produce any pulse.
        cur = "garbage";
        sh  = 8'h00;
        d0  = n_done;
        e0  = n_err;
        for (int i = 0; i < 200; i++) begin
            b = 1'($urandom_range(0, 1));
            if ({sh[6:0], b} == SYNC) b = ~b;
            sh = {sh[6:0], b};
            send_bit(b, 1'b0);
        end
        @(posedge clock);
        #1;
        chk("done_count", n_done - d0, 0);
        chk("err_count", n_err - e0, 0);
        chk("busy", busy, 1'b0);

        // Mid-frame reset after a good commit clears everything at once.
        f = '1;
        run_frame("pre_reset_ones", f, 8'h00, 1'b0, 0, 1'b1);
        cur = "mid_reset";
        send_byte(8'h00, 1'b0);
        send_byte(SYNC, 1'b0);
        for (int i = 0; i < 300; i++) send_bit(rnd_frame[i], 1'b0);
        chk("busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("tile", cfg_tile, '0);
        chk("sb", cfg_sb, '0);
        chk("ready", cfg_ready, 1'b0);
        chk("busy", busy, 1'b0);
        @(negedge clock);
        reset_n     = 1'b1;
        model_tile  = '0;
        model_sb    = '0;
        model_ready = 1'b0;
        @(posedge clock);
        #1;
        run_frame("post_reset", rnd_frame, 8'h00, 1'b0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
